fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined CPU, directly upstream of the hazard bubbler and decode. It owns the PC, drives the instruction-memory address, and registers the IF/ID pipeline latch. It holds the PC and injects NOPs when the hazard unit requests a bubble. It redirects the PC on taken branches and JAL, and freezes on halt. Saturating fetch and bubble counters are provided for performance debug.

## Interface
- ADDR_W, 32, PC and address width
- RESET_PC, 0, PC value loaded on reset
- NOP_INST, 32'h00000000, encoding injected into the IF/ID latch on bubble, flush, boot or halt
- CNT_W, 16, width of each saturating performance counter
- clk  input  1  pipeline clock; all state updates on posedge
- reset  input  1  asynchronous, active-high
- bubbleIn  input  1  hazard unit bubble request; hold PC and issue NOP
- redirectEn  input  1  taken branch or JAL resolved this cycle
- redirectPc  input  ADDR_W  target address for redirectEn
- haltIn  input  1  decode saw a halt instruction; stop fetching
- imemAddr  output  ADDR_W  combinational, equals current PC
- imemData  input  32  asynchronous instruction memory read data for imemAddr
- instOut  output  32  IF/ID latched instruction
- pcOut  output  ADDR_W  IF/ID latched PC+4 of instOut
- validOut  output  1  IF/ID latch holds a real instruction (0 means NOP)
- fetchCount  output  CNT_W  number of valid instructions issued, saturating
- bubbleCount  output  CNT_W  number of NOPs issued in RUN, saturating

## Operation
- States:
  - BOOT: entered on reset; lasts one cycle.
  - RUN: normal fetch.
  - HALTED: terminal; left only by reset.
- BOOT -> RUN unconditionally on the first posedge after reset deasserts. During that edge the latch loads NOP, validOut=0, and the PC is unchanged.
- In RUN, each posedge applies the highest-priority applicable case below:
  1. haltIn=1: go to HALTED, latch NOP, PC unchanged. Halt beats redirect and bubble.
  2. redirectEn=1: PC <= redirectPc, latch NOP (flush of the wrong-path fetch), bubbleCount++. Redirect beats bubble.
  3. bubbleIn=1: PC unchanged, latch NOP, bubbleCount++.
  4. Otherwise: instOut <= imemData, pcOut <= PC+4, validOut <= 1, PC <= PC+4, fetchCount++.
- HALTED: the PC is frozen, the latch holds NOP with validOut=0, and all inputs except reset are ignored. Counters are frozen.
- PC arithmetic: PC+4 is modulo 2^ADDR_W, so 0xFFFFFFFC wraps to 0x00000000 with no flag. redirectPc is taken verbatim; there is no alignment check.
- When a NOP is latched, pcOut is loaded with 0.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Reset (asynchronous, immediate) values:
  - PC=RESET_PC, so imemAddr=RESET_PC
  - instOut=NOP_INST, pcOut=0, validOut=0
  - fetchCount=0, bubbleCount=0
  - state=BOOT
- Reset asserted mid-operation overrides every state at once, with no waiting for a clock edge.
- Fetch latency: the instruction at PC appears on instOut one posedge after imemAddr=PC, provided no bubble, redirect or halt occurs on that edge.
- The first valid instruction after reset deassertion appears on instOut at the 2nd posedge (BOOT cycle, then fetch).
- bubbleIn comes from a negedge register in the hazard unit and is stable at posedge; it is sampled only at posedge.
- Redirect penalty: on the redirect edge the latch gets NOP and the PC becomes redirectPc. The target instruction is on instOut one edge later, a 1-cycle bubble in total.
- A bubble held for N consecutive cycles produces N NOPs, leaves the PC constant for N cycles, and adds N to bubbleCount.

## Test plan
- Reset/boot: hold reset 3 cycles, release with RESET_PC=0 and a ROM where word k = 0x1000+k. Required: edge 1 gives validOut=0; edge 2 gives instOut=0x1000, pcOut=4, validOut=1; edge 3 gives instOut=0x1001, pcOut=8.
- Bubble: in a straight-line run at PC=0x10, assert bubbleIn for 2 cycles. Required: 2 NOPs with validOut=0, imemAddr stays 0x10, then instOut=ROM[0x10] with pcOut=0x14; bubbleCount=2.
- Redirect vs bubble: at PC=0x20 assert redirectEn=1, redirectPc=0x80 and bubbleIn=1 together. Required: next edge latches NOP and sets imemAddr=0x80; the following edge gives instOut=ROM[0x80], pcOut=0x84; bubbleCount increments by exactly 1.
- Halt: assert haltIn together with redirectEn. Required: state HALTED, PC unchanged, validOut=0 for 10 further cycles, counters frozen. Then assert reset: outputs return to reset values immediately.
- Wrap and saturation: with RESET_PC=0xFFFFFFF8 and CNT_W=4, run 20 cycles. Required: imemAddr goes 0xFFFFFFF8 -> 0xFFFFFFFC -> 0x0, pcOut after the 0xFFFFFFFC fetch is 0x0, and fetchCount stops at 15.
- Asynchronous reset mid-run: assert reset between clock edges during a bubble. Required: instOut=NOP_INST, imemAddr=RESET_PC and counters=0 before the next posedge.

Source files
------------

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage: PC ownership, IF/ID latch, bubble,
//             redirect and halt handling, saturating perf counters.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]       NOP_INST = 32'h0000_0000,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bubbleIn,
    input  logic              redirectEn,
    input  logic [ADDR_W-1:0] redirectPc,
    input  logic              haltIn,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic [31:0]       imemData,
    output logic [31:0]       instOut,
    output logic [ADDR_W-1:0] pcOut,
    output logic              validOut,
    output logic [CNT_W-1:0]  fetchCount,
    output logic [CNT_W-1:0]  bubbleCount
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pcNext;
    logic [ADDR_W-1:0]  w_pcPlus4;

    logic [31:0]        r_inst;
    logic [31:0]        w_instNext;
    logic [ADDR_W-1:0]  r_pcOut;
    logic [ADDR_W-1:0]  w_pcOutNext;
    logic               r_valid;
    logic               w_validNext;

    logic [CNT_W-1:0]   r_fetchCount;
    logic [CNT_W-1:0]   r_bubbleCount;
    logic [CNT_W-1:0]   w_fetchNext;
    logic [CNT_W-1:0]   w_bubbleNext;
    logic [CNT_W-1:0]   w_fetchSat;
    logic [CNT_W-1:0]   w_bubbleSat;

    // PC+4 wraps modulo 2^ADDR_W by construction of the adder width.
    assign w_pcPlus4   = r_pc + ADDR_W'(4);
    assign w_fetchSat  = (&r_fetchCount)  ? r_fetchCount  : r_fetchCount  + CNT_W'(1);
    assign w_bubbleSat = (&r_bubbleCount) ? r_bubbleCount : r_bubbleCount + CNT_W'(1);

    // Every non-fetch outcome latches a NOP with pcOut=0, so those are the defaults.
    always_comb begin
        w_stateNext  = r_state;
        w_pcNext     = r_pc;
        w_instNext   = NOP_INST;
        w_pcOutNext  = '0;
        w_validNext  = 1'b0;
        w_fetchNext  = r_fetchCount;
        w_bubbleNext = r_bubbleCount;
        case (r_state)
            BOOT: begin
                w_stateNext = RUN;
            end
            RUN: begin
                if (haltIn) begin
                    w_stateNext = HALTED;
                end else if (redirectEn) begin
                    w_pcNext     = redirectPc;
                    w_bubbleNext = w_bubbleSat;
                end else if (bubbleIn) begin
                    w_bubbleNext = w_bubbleSat;
                end else begin
                    w_instNext  = imemData;
                    w_pcOutNext = w_pcPlus4;
                    w_validNext = 1'b1;
                    w_pcNext    = w_pcPlus4;
                    w_fetchNext = w_fetchSat;
                end
            end
            HALTED: begin
                w_stateNext = HALTED;
            end
            default: begin
                w_stateNext = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_inst        <= NOP_INST;
            r_pcOut       <= '0;
            r_valid       <= 1'b0;
            r_fetchCount  <= '0;
            r_bubbleCount <= '0;
        end else begin
            r_state       <= w_stateNext;
            r_pc          <= w_pcNext;
            r_inst        <= w_instNext;
            r_pcOut       <= w_pcOutNext;
            r_valid       <= w_validNext;
            r_fetchCount  <= w_fetchNext;
            r_bubbleCount <= w_bubbleNext;
        end
    end

    assign imemAddr    = r_pc;
    assign instOut     = r_inst;
    assign pcOut       = r_pcOut;
    assign validOut    = r_valid;
    assign fetchCount  = r_fetchCount;
    assign bubbleCount = r_bubbleCount;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed self-checking bench for fetch_unit (default instance
//             plus a wrap/saturation instance).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        rst2;
    logic        bubbleIn;
    logic        redirectEn;
    logic [31:0] redirectPc;
    logic        haltIn;

    logic [31:0] imemAddr, imemData, instOut, pcOut;
    logic        validOut;
    logic [15:0] fetchCount, bubbleCount;

    logic [31:0] imemAddr2, imemData2, instOut2, pcOut2;
    logic        validOut2;
    logic [3:0]  fetchCount2, bubbleCount2;

    int checks = 0;
    int errors = 0;

    // ROM: word k holds 0x1000 + k
    assign imemData  = 32'h1000 + (imemAddr  >> 2);
    assign imemData2 = 32'h1000 + (imemAddr2 >> 2);

    fetch_unit u_dut (
        .clk(clk), .reset(reset), .bubbleIn(bubbleIn), .redirectEn(redirectEn),
        .redirectPc(redirectPc), .haltIn(haltIn), .imemAddr(imemAddr),
        .imemData(imemData), .instOut(instOut), .pcOut(pcOut), .validOut(validOut),
        .fetchCount(fetchCount), .bubbleCount(bubbleCount)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(4)) u_wrap (
        .clk(clk), .reset(rst2), .bubbleIn(1'b0), .redirectEn(1'b0),
        .redirectPc(32'h0), .haltIn(1'b0), .imemAddr(imemAddr2),
        .imemData(imemData2), .instOut(instOut2), .pcOut(pcOut2), .validOut(validOut2),
        .fetchCount(fetchCount2), .bubbleCount(bubbleCount2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; rst2 = 1'b1;
        bubbleIn = 1'b0; redirectEn = 1'b0; redirectPc = '0; haltIn = 1'b0;
        repeat (3) @(negedge clk);

        checkEq("rst_addr",   imemAddr,    32'h0);
        checkEq("rst_inst",   instOut,     32'h0);
        checkEq("rst_pcOut",  pcOut,       32'h0);
        checkEq("rst_valid",  validOut,    1'b0);
        checkEq("rst_fcnt",   fetchCount,  16'd0);
        checkEq("rst_bcnt",   bubbleCount, 16'd0);

        reset = 1'b0;
        tick();  // edge 1: BOOT
        checkEq("boot_valid", validOut, 1'b0);
        checkEq("boot_addr",  imemAddr, 32'h0);
        tick();  // edge 2: first fetch
        checkEq("e2_inst",  instOut,  32'h1000);
        checkEq("e2_pc",    pcOut,    32'h4);
        checkEq("e2_valid", validOut, 1'b1);
        tick();  // edge 3
        checkEq("e3_inst", instOut, 32'h1001);
        checkEq("e3_pc",   pcOut,   32'h8);
        tick(); tick();  // edges 4,5 -> PC=0x10
        checkEq("pre_bub_addr", imemAddr, 32'h10);

        // two-cycle bubble at PC=0x10
        bubbleIn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkEq("bub_valid", validOut, 1'b0);
            checkEq("bub_inst",  instOut,  32'h0);
            checkEq("bub_pcOut", pcOut,    32'h0);
            checkEq("bub_addr",  imemAddr, 32'h10);
        end
        bubbleIn = 1'b0;
        tick();  // edge 8
        checkEq("post_bub_inst", instOut,     32'h1004);
        checkEq("post_bub_pc",   pcOut,       32'h14);
        checkEq("bub_count",     bubbleCount, 16'd2);
        checkEq("fetch_count5",  fetchCount,  16'd5);

        tick(); tick(); tick();  // edges 9-11 -> PC=0x20
        checkEq("pre_redir_addr", imemAddr, 32'h20);

        // redirect and bubble together: redirect wins, one bubble counted
        redirectEn = 1'b1; redirectPc = 32'h80; bubbleIn = 1'b1;
        tick();  // edge 12
        checkEq("redir_valid", validOut,    1'b0);
        checkEq("redir_addr",  imemAddr,    32'h80);
        checkEq("redir_bcnt",  bubbleCount, 16'd3);
        redirectEn = 1'b0; bubbleIn = 1'b0;
        tick();  // edge 13
        checkEq("tgt_inst",  instOut,     32'h1020);
        checkEq("tgt_pc",    pcOut,       32'h84);
        checkEq("tgt_bcnt",  bubbleCount, 16'd3);
        checkEq("tgt_fcnt",  fetchCount,  16'd9);

        // halt beats redirect; afterwards all inputs are ignored
        haltIn = 1'b1; redirectEn = 1'b1; redirectPc = 32'h40;
        tick();  // edge 14
        haltIn = 1'b0; bubbleIn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkEq("halt_valid", validOut, 1'b0);
            checkEq("halt_addr",  imemAddr, 32'h84);
            tick();
        end
        checkEq("halt_fcnt", fetchCount,  16'd9);
        checkEq("halt_bcnt", bubbleCount, 16'd3);
        checkEq("halt_inst", instOut,     32'h0);
        redirectEn = 1'b0; bubbleIn = 1'b0;

        // asynchronous reset out of HALTED
        #2 reset = 1'b1;
        #1;
        checkEq("hrst_addr",  imemAddr,    32'h0);
        checkEq("hrst_valid", validOut,    1'b0);
        checkEq("hrst_fcnt",  fetchCount,  16'd0);
        checkEq("hrst_bcnt",  bubbleCount, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        tick(); tick(); tick();  // BOOT, fetch 0x0, fetch 0x4 -> PC=0x8
        checkEq("rerun_addr", imemAddr, 32'h8);
        bubbleIn = 1'b1;
        tick();
        checkEq("rerun_bcnt", bubbleCount, 16'd1);

        // asynchronous reset between edges during a bubble
        #2 reset = 1'b1;
        #1;
        checkEq("arst_inst", instOut,     32'h0);
        checkEq("arst_addr", imemAddr,    32'h0);
        checkEq("arst_fcnt", fetchCount,  16'd0);
        checkEq("arst_bcnt", bubbleCount, 16'd0);
        @(negedge clk);
        reset = 1'b0; bubbleIn = 1'b0;

        // wrap and saturation instance
        rst2 = 1'b0;
        tick();  // BOOT
        checkEq("w_boot_addr",  imemAddr2, 32'hFFFF_FFF8);
        checkEq("w_boot_valid", validOut2, 1'b0);
        tick();  // fetch 0xFFFFFFF8
        checkEq("w_e2_addr", imemAddr2, 32'hFFFF_FFFC);
        checkEq("w_e2_pc",   pcOut2,    32'hFFFF_FFFC);
        checkEq("w_e2_inst", instOut2,  32'h4000_0FFE);
        tick();  // fetch 0xFFFFFFFC, PC wraps
        checkEq("w_e3_addr",  imemAddr2, 32'h0);
        checkEq("w_e3_pc",    pcOut2,    32'h0);
        checkEq("w_e3_inst",  instOut2,  32'h4000_0FFF);
        checkEq("w_e3_valid", validOut2, 1'b1);
        repeat (12) tick();  // edge 15: 14 fetches
        checkEq("w_fcnt14", fetchCount2, 4'd14);
        repeat (5) tick();   // edge 20: saturated
        checkEq("w_fcnt15", fetchCount2,  4'd15);
        checkEq("w_bcnt",   bubbleCount2, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
